flash_boot_loader: RTL and testbench

Upstream write master for the user flash store: it receives a framed program image byte-by-byte from the UART receiver, packs bytes into little-endian 32-bit words, and writes them into consecutive flash word addresses over the flash select/ready port. It holds the CPU in reset until a complete image with a valid checksum has been stored, then releases it. It sits between the UART RX stage and the flash store's write port, muxed onto that port only while `cpu_hold` is high.

---
 rtl/flash_boot_loader_if.sv | 13 +
 rtl/flash_boot_loader.sv | 191 +++++++++++++++++++
 tb/tb_flash_boot_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/flash_boot_loader_if.sv
// Flash write-port bundle between the boot loader (master) and the flash store (slave).
interface flash_boot_loader_if #(
  parameter int ADDR_W = 15
);
  logic              select;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_o;
  logic              ready;

  modport master (output select, wstrb, addr, data_o, input ready);
  modport slave  (input select, wstrb, addr, data_o, output ready);
endinterface

// File: rtl/flash_boot_loader.sv
// UART-fed boot loader: packs framed bytes into flash words, releases the CPU on a good checksum.
// Optional inter-byte timeout enabled by defining BOOT_TIMEOUT_EN.
module flash_boot_loader #(
  parameter int ADDR_W         = 15,
  parameter int DEPTH          = 8192,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  flash_boot_loader_if.master flash,
  output logic                cpu_hold,
  output logic                boot_done,
  output logic                boot_err,
  output logic [2:0]          err_code
);

  typedef enum logic [3:0] {IDLE, LEN0, LEN1, DATA, WRITE, WAIT, CSUM, DONE, ERROR} state_t;

  state_t            state_reg;
  logic [7:0]        len_lo_reg;
  logic [15:0]       len_reg;
  logic [15:0]       word_idx_reg;
  logic [1:0]        lane_reg;
  logic [7:0]        xor_reg;
  logic              select_reg;
  logic [3:0]        wstrb_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       data_reg;
  logic              cpu_hold_reg;
  logic              boot_done_reg;
  logic              boot_err_reg;
  logic [2:0]        err_code_reg;

  logic [23:0]       lane_bytes;
  logic [15:0]       len_next;
  logic [15:0]       idx_next;
  logic              len_bad;
  logic              timeout_hit;

  assign len_next = {rx_data, len_lo_reg};
  assign idx_next = word_idx_reg + 16'd1;
  assign len_bad  = (len_next == 16'd0) || (32'(len_next) > 32'(DEPTH));

  // Lanes 0..2 are buffered; lane 3 goes straight from rx_data into the write word.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] byte_reg;
      always_ff @(posedge clk) begin
        if (reset)
          byte_reg <= '0;
        else if (state_reg == DATA && rx_valid && lane_reg == 2'(gi))
          byte_reg <= rx_data;
      end
      assign lane_bytes[gi*8 +: 8] = byte_reg;
    end
  endgenerate

`ifdef BOOT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_reg;
  logic             counting;

  assign counting    = (state_reg == LEN0) || (state_reg == LEN1) ||
                       (state_reg == DATA) || (state_reg == CSUM);
  assign timeout_hit = counting && !rx_valid &&
                       (idle_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // Holds its value across WRITE/WAIT so the gap is measured from the last byte.
  always_ff @(posedge clk) begin
    if (reset || rx_valid)
      idle_cnt_reg <= '0;
    else if (counting && !timeout_hit)
      idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
  end
`else
  // No inter-byte timer in this build; the comparison is constant false.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      len_lo_reg    <= '0;
      len_reg       <= '0;
      word_idx_reg  <= '0;
      lane_reg      <= '0;
      xor_reg       <= '0;
      select_reg    <= 1'b0;
      wstrb_reg     <= 4'b0000;
      addr_reg      <= '0;
      data_reg      <= '0;
      cpu_hold_reg  <= 1'b1;
      boot_done_reg <= 1'b0;
      boot_err_reg  <= 1'b0;
      err_code_reg  <= 3'd0;
    end else begin
      select_reg <= 1'b0;
      wstrb_reg  <= 4'b0000;
      case (state_reg)
        IDLE, ERROR: begin
          if (rx_valid && rx_data == 8'hA5) begin
            state_reg    <= LEN0;
            word_idx_reg <= '0;
            lane_reg     <= '0;
            xor_reg      <= '0;
            boot_err_reg <= 1'b0;
            err_code_reg <= 3'd0;
          end
        end
        LEN0: begin
          if (timeout_hit) begin
            state_reg <= ERROR; boot_err_reg <= 1'b1; err_code_reg <= 3'd4;
          end else if (rx_valid) begin
            len_lo_reg <= rx_data;
            state_reg  <= LEN1;
          end
        end
        LEN1: begin
          if (timeout_hit) begin
            state_reg <= ERROR; boot_err_reg <= 1'b1; err_code_reg <= 3'd4;
          end else if (rx_valid) begin
            if (len_bad) begin
              state_reg <= ERROR; boot_err_reg <= 1'b1; err_code_reg <= 3'd1;
            end else begin
              len_reg   <= len_next;
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (timeout_hit) begin
            state_reg <= ERROR; boot_err_reg <= 1'b1; err_code_reg <= 3'd4;
          end else if (rx_valid) begin
            xor_reg  <= xor_reg ^ rx_data;
            lane_reg <= lane_reg + 2'd1;
            if (lane_reg == 2'd3) begin
              select_reg <= 1'b1;
              wstrb_reg  <= 4'b1111;
              addr_reg   <= ADDR_W'(word_idx_reg);
              data_reg   <= {rx_data, lane_bytes};
              state_reg  <= WRITE;
            end
          end
        end
        WRITE: begin
          if (rx_valid) begin
            state_reg <= ERROR; boot_err_reg <= 1'b1; err_code_reg <= 3'd3;
          end else begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (rx_valid) begin
            state_reg <= ERROR; boot_err_reg <= 1'b1; err_code_reg <= 3'd3;
          end else if (flash.ready) begin
            word_idx_reg <= idx_next;
            state_reg    <= (idx_next == len_reg) ? CSUM : DATA;
          end
        end
        CSUM: begin
          if (timeout_hit) begin
            state_reg <= ERROR; boot_err_reg <= 1'b1; err_code_reg <= 3'd4;
          end else if (rx_valid) begin
            if (rx_data == xor_reg) begin
              state_reg     <= DONE;
              boot_done_reg <= 1'b1;
              cpu_hold_reg  <= 1'b0;
            end else begin
              state_reg <= ERROR; boot_err_reg <= 1'b1; err_code_reg <= 3'd2;
            end
          end
        end
        DONE: ;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign flash.select = select_reg;
  assign flash.wstrb  = wstrb_reg;
  assign flash.addr   = addr_reg;
  assign flash.data_o = data_reg;
  assign cpu_hold     = cpu_hold_reg;
  assign boot_done    = boot_done_reg;
  assign boot_err     = boot_err_reg;
  assign err_code     = err_code_reg;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench for flash_boot_loader with a one-cycle-ready flash model.
module tb_flash_boot_loader;
  localparam int ADDR_W = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cpu_hold, boot_done, boot_err;
  logic [2:0] err_code;
  logic       ready_en = 1'b1;

  flash_boot_loader_if #(.ADDR_W(ADDR_W)) flash();

  flash_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(8192), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .flash(flash), .cpu_hold(cpu_hold), .boot_done(boot_done),
    .boot_err(boot_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Flash store model: acknowledges the cycle after select, records written words.
  logic [31:0] mem [16];
  int sel_count = 0;
  int strb_bad = 0;
  always @(posedge clk) begin
    flash.ready <= flash.select && ready_en;
    if (flash.select) begin
      mem[flash.addr[3:0]] <= flash.data_o;
      sel_count <= sel_count + 1;
      if (flash.wstrb != 4'hF) strb_bad <= strb_bad + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] frame[$];
  int s0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame();
    foreach (frame[i]) begin
      strobe(frame[i]);
      if (i != frame.size() - 1) idle(3);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".select"},    32'(flash.select), 32'd0);
    check({tag, ".wstrb"},     32'(flash.wstrb),  32'd0);
    check({tag, ".addr"},      32'(flash.addr),   32'd0);
    check({tag, ".data_o"},    flash.data_o,      32'd0);
    check({tag, ".cpu_hold"},  32'(cpu_hold),     32'd1);
    check({tag, ".boot_done"}, 32'(boot_done),    32'd0);
    check({tag, ".boot_err"},  32'(boot_err),     32'd0);
    check({tag, ".err_code"},  32'(err_code),     32'd0);
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    check_reset("por");

    // Good two-word frame
    s0 = sel_count;
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    send_frame();
    check("good.boot_done", 32'(boot_done), 32'd1);
    check("good.cpu_hold",  32'(cpu_hold),  32'd0);
    check("good.boot_err",  32'(boot_err),  32'd0);
    check("good.selects",   32'(sel_count - s0), 32'd2);
    check("good.mem0",      mem[0], 32'h44332211);
    check("good.mem1",      mem[1], 32'h88776655);

    // Bad checksum, then the good frame again
    do_reset();
    s0 = sel_count;
    frame[11] = 8'h00;
    send_frame();
    check("csum.boot_err",  32'(boot_err),  32'd1);
    check("csum.err_code",  32'(err_code),  32'd2);
    check("csum.cpu_hold",  32'(cpu_hold),  32'd1);
    check("csum.boot_done", 32'(boot_done), 32'd0);
    check("csum.selects",   32'(sel_count - s0), 32'd2);
    idle(3);
    frame[11] = 8'h88;
    send_frame();
    check("retry.boot_done", 32'(boot_done), 32'd1);
    check("retry.boot_err",  32'(boot_err),  32'd0);
    check("retry.err_code",  32'(err_code),  32'd0);
    check("retry.cpu_hold",  32'(cpu_hold),  32'd0);

    // Length 0 and length 8193
    do_reset();
    s0 = sel_count;
    frame = '{8'hA5, 8'h00, 8'h00};
    send_frame();
    check("len0.err_code", 32'(err_code), 32'd1);
    check("len0.boot_err", 32'(boot_err), 32'd1);
    idle(3);
    strobe(8'hA5);
    check("restart.err_code", 32'(err_code), 32'd0);
    check("restart.boot_err", 32'(boot_err), 32'd0);
    idle(3);
    strobe(8'h01);
    idle(3);
    strobe(8'h20);
    check("len8193.err_code", 32'(err_code), 32'd1);
    idle(3);
    check("len.selects", 32'(sel_count - s0), 32'd0);

    // Overrun: byte in the cycle after the 4th payload byte
    do_reset();
    s0 = sel_count;
    frame = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03};
    send_frame();
    idle(3);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h04;
    @(negedge clk); rx_data = 8'h55;
    check("ovr.select", 32'(flash.select), 32'd1);
    check("ovr.wstrb",  32'(flash.wstrb),  32'hF);
    check("ovr.addr",   32'(flash.addr),   32'd0);
    check("ovr.data_o", flash.data_o,      32'h04030201);
    @(negedge clk); rx_valid = 1'b0;
    check("ovr.err_code", 32'(err_code), 32'd3);
    check("ovr.boot_err", 32'(boot_err), 32'd1);
    check("ovr.select_low", 32'(flash.select), 32'd0);
    check("ovr.mem0",   mem[0], 32'h04030201);
    check("ovr.selects", 32'(sel_count - s0), 32'd1);

    // Inter-byte gap after 5 payload bytes
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame();
`ifdef BOOT_TIMEOUT_EN
    idle(99);
    check("tmo.before", 32'(err_code), 32'd0);
    idle(1);
    check("tmo.err_code", 32'(err_code), 32'd4);
    check("tmo.boot_err", 32'(boot_err), 32'd1);
`else
    idle(150);
    check("gap.err_code", 32'(err_code), 32'd0);
    check("gap.boot_err", 32'(boot_err), 32'd0);
    idle(2);
    frame = '{8'h06, 8'h07, 8'h08, 8'h08};
    send_frame();
    check("gap.boot_done", 32'(boot_done), 32'd1);
    check("gap.mem0", mem[0], 32'h04030201);
    check("gap.mem1", mem[1], 32'h08070605);
`endif

    // Reset while stalled in WAIT, then a fresh frame from addr 0
    do_reset();
    ready_en = 1'b0;
    frame = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame();
    idle(3);
    check("wait.data_o", flash.data_o, 32'hEFBEADDE);
    check("wait.select", 32'(flash.select), 32'd0);
    do_reset();
    check_reset("wait_rst");
    ready_en = 1'b1;
    idle(3);
    frame = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40};
    send_frame();
    check("reload.boot_done", 32'(boot_done), 32'd1);
    check("reload.addr",      32'(flash.addr), 32'd0);
    check("reload.mem0",      mem[0], 32'h40302010);
    check("wstrb.all_writes", 32'(strb_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
